// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end that drives a combinational ALU,
// waits SETTLE cycles for it to resolve, and returns a registered response.
module alu_op_sequencer #(
   parameter int W      = 4,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_Ctrl,
   input  logic [W-1:0] cmd_A,
   input  logic [W-1:0] cmd_B,
   output logic [2:0]   alu_Ctrl,
   output logic [W-1:0] alu_A,
   output logic [W-1:0] alu_B,
   input  logic [W-1:0] alu_R,
   input  logic         alu_cout,
   input  logic         alu_overflow,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_R,
   output logic         rsp_cout,
   output logic         rsp_overflow,
   output logic         rsp_zero,
   output logic [2:0]   rsp_Ctrl,
   output logic         busy
);
   localparam logic [2:0] ADD_ = 3'd0;
   localparam logic [2:0] SUB_ = 3'd1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

   state_t         state_q;
   logic [3:0]     cnt_q;
   logic [2:0]     alu_Ctrl_q, rsp_Ctrl_q;
   logic [W-1:0]   alu_A_q, alu_B_q, rsp_R_q;
   logic           rsp_valid_q, rsp_cout_q, rsp_overflow_q, rsp_zero_q;
   logic           arith;

   // carry/overflow are only driven by the ALU for add and subtract
   assign arith = alu_Ctrl_q == ADD_ || alu_Ctrl_q == SUB_;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         alu_Ctrl_q     <= '0;
         alu_A_q        <= '0;
         alu_B_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_R_q        <= '0;
         rsp_cout_q     <= 1'b0;
         rsp_overflow_q <= 1'b0;
         rsp_zero_q     <= 1'b0;
         rsp_Ctrl_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE:
               if (cmd_valid) begin
                  alu_Ctrl_q <= cmd_Ctrl;
                  alu_A_q    <= cmd_A;
                  alu_B_q    <= cmd_B;
                  cnt_q      <= 4'(SETTLE - 1);
                  state_q    <= S_SETTLE;
               end
            S_SETTLE:
               if (cnt_q == 4'd0) begin
                  rsp_R_q        <= alu_R;
                  rsp_zero_q     <= ~|alu_R;
                  rsp_Ctrl_q     <= alu_Ctrl_q;
                  rsp_cout_q     <= arith ? alu_cout : 1'b0;
                  rsp_overflow_q <= arith ? alu_overflow : 1'b0;
                  rsp_valid_q    <= 1'b1;
                  state_q        <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            S_RESP:
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready    = state_q == S_IDLE;
   assign busy         = state_q != S_IDLE;
   assign alu_Ctrl     = alu_Ctrl_q;
   assign alu_A        = alu_A_q;
   assign alu_B        = alu_B_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_R        = rsp_R_q;
   assign rsp_cout     = rsp_cout_q;
   assign rsp_overflow = rsp_overflow_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_Ctrl     = rsp_Ctrl_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives the sequencer against a behavioural ALU and
// checks responses, timing, backpressure and reset abort.
module tb_alu_op_sequencer;
   localparam int W = 4;
   localparam int SETTLE = 2;
   localparam logic [2:0] ADD_ = 3'd0, SUB_ = 3'd1, XOR_ = 3'd2, SLT_ = 3'd3,
                          AND_ = 3'd4, NAND_ = 3'd5, NOR_ = 3'd6, OR_ = 3'd7;

   logic clk = 0, rst_n = 0;
   logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, busy;
   logic [2:0] cmd_Ctrl = 0, alu_Ctrl, rsp_Ctrl;
   logic [W-1:0] cmd_A = 0, cmd_B = 0, alu_A, alu_B, alu_R, rsp_R;
   logic alu_cout, alu_overflow, rsp_cout, rsp_overflow, rsp_zero;
   int errs = 0, checks = 0;

   alu_op_sequencer #(.W(W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_Ctrl(cmd_Ctrl), .cmd_A(cmd_A), .cmd_B(cmd_B),
      .alu_Ctrl(alu_Ctrl), .alu_A(alu_A), .alu_B(alu_B),
      .alu_R(alu_R), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_R(rsp_R),
      .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .rsp_Ctrl(rsp_Ctrl), .busy(busy)
   );

   always #5 clk = ~clk;

   // returns {overflow, cout, R} as an ideal ALU would
   function automatic logic [W+1:0] alu_ref(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      logic v;
      v = 1'b0;
      case (c)
         ADD_: begin s = {1'b0, a} + {1'b0, b}; v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
         SUB_: begin s = {1'b0, a} + {1'b0, ~b} + 1; v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
         XOR_: s = {1'b0, a ^ b};
         SLT_: s = ($signed(a) < $signed(b)) ? 1 : 0;
         AND_: s = {1'b0, a & b};
         NAND_: s = {1'b0, ~(a & b)};
         NOR_: s = {1'b0, ~(a | b)};
         default: s = {1'b0, a | b};
      endcase
      return {v, s};
   endfunction

   // non-arithmetic ops leave the flags floating; model that as stale highs
   always_comb begin
      {alu_overflow, alu_cout, alu_R} = alu_ref(alu_Ctrl, alu_A, alu_B);
      if (alu_Ctrl != ADD_ && alu_Ctrl != SUB_) {alu_overflow, alu_cout} = 2'b11;
   end

   task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      @(negedge clk);
      cmd_valid = 1; cmd_Ctrl = c; cmd_A = a; cmd_B = b;
      @(posedge clk); #1 cmd_valid = 0;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = i; break; end
      end
   endtask

   task automatic release_rsp();
      @(negedge clk); rsp_ready = 1;
      @(posedge clk); #1 rsp_ready = 0;
   endtask

   task automatic test_reset();
      cmd_valid = 1;
      repeat (2) @(posedge clk);
      #1 checks++;
      if ({cmd_ready, busy, rsp_valid, alu_Ctrl, alu_A, alu_B, rsp_R, rsp_cout, rsp_overflow, rsp_zero, rsp_Ctrl} !== 24'h800000) begin
         errs++; $display("FAIL reset_outputs got %h want 800000", {cmd_ready, busy, rsp_valid, alu_Ctrl, alu_A, alu_B, rsp_R, rsp_cout, rsp_overflow, rsp_zero, rsp_Ctrl});
      end
      cmd_valid = 0;
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_basic();
      int lat;
      checks++; if (cmd_ready !== 1) begin errs++; $display("FAIL idle_ready got %b want 1", cmd_ready); end
      send(ADD_, 4'h7, 4'h2, lat);
      checks++; if (lat != SETTLE) begin errs++; $display("FAIL add_latency got %0d want %0d", lat, SETTLE); end
      checks++; if ({rsp_R, rsp_cout, rsp_overflow, rsp_zero, rsp_Ctrl} !== {4'h9, 1'b0, 1'b1, 1'b0, ADD_}) begin
         errs++; $display("FAIL add_7_2 got R=%h c=%b v=%b z=%b op=%0d want R=9 c=0 v=1 z=0 op=0", rsp_R, rsp_cout, rsp_overflow, rsp_zero, rsp_Ctrl);
      end
      release_rsp();
      checks++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin errs++; $display("FAIL release got %b want 010", {rsp_valid, cmd_ready, busy}); end
      checks++; if ({alu_Ctrl, alu_A, alu_B, rsp_R} !== {ADD_, 4'h7, 4'h2, 4'h9}) begin errs++; $display("FAIL hold_after_idle got %h", {alu_Ctrl, alu_A, alu_B, rsp_R}); end
      send(ADD_, 4'hF, 4'h1, lat);
      checks++; if ({rsp_R, rsp_cout, rsp_zero} !== {4'h0, 1'b1, 1'b1}) begin errs++; $display("FAIL add_F_1 got R=%h c=%b z=%b want R=0 c=1 z=1", rsp_R, rsp_cout, rsp_zero); end
      release_rsp();
      send(SUB_, 4'h5, 4'h5, lat);
      checks++; if ({rsp_R, rsp_zero, rsp_Ctrl} !== {4'h0, 1'b1, SUB_}) begin errs++; $display("FAIL sub_5_5 got R=%h z=%b op=%0d want R=0 z=1 op=1", rsp_R, rsp_zero, rsp_Ctrl); end
      release_rsp();
      send(XOR_, 4'hA, 4'h5, lat);
      checks++; if ({rsp_R, rsp_cout, rsp_overflow, rsp_zero} !== {4'hF, 1'b0, 1'b0, 1'b0}) begin
         errs++; $display("FAIL xor_mask got R=%h c=%b v=%b z=%b want R=F c=0 v=0 z=0", rsp_R, rsp_cout, rsp_overflow, rsp_zero);
      end
      release_rsp();
   endtask

   task automatic test_backpressure();
      int lat;
      send(ADD_, 4'h3, 4'h4, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmd_valid = 1'($urandom); cmd_Ctrl = 3'($urandom); cmd_A = 4'($urandom); cmd_B = 4'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({cmd_ready, busy, rsp_valid, alu_Ctrl, alu_A, alu_B, rsp_R, rsp_Ctrl} !== {3'b011, ADD_, 4'h3, 4'h4, 4'h7, ADD_}) begin
            errs++; $display("FAIL backpressure_hold cyc=%0d got %h", i, {cmd_ready, busy, rsp_valid, alu_Ctrl, alu_A, alu_B, rsp_R, rsp_Ctrl});
         end
      end
      cmd_valid = 0;
      release_rsp();
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errs++; $display("FAIL backpressure_release got %b want 01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops [4] = '{AND_, OR_, NAND_, NOR_};
      logic [W-1:0] want [4] = '{4'h8, 4'hE, 4'h7, 4'h1};
      logic [W-1:0] got [$];
      int at [$];
      int n = 0;
      rsp_ready = 1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (cmd_ready) begin
            cmd_valid = n < 4;
            if (n < 4) begin cmd_Ctrl = ops[n]; cmd_A = 4'hC; cmd_B = 4'hA; n++; end
         end else begin
            cmd_valid = 1; cmd_Ctrl = 3'($urandom); cmd_A = 4'($urandom); cmd_B = 4'($urandom);
         end
         @(posedge clk); #1;
         if (rsp_valid) begin got.push_back(rsp_R); at.push_back(cyc); end
      end
      cmd_valid = 0; rsp_ready = 0;
      checks++; if (got.size() != 4) begin errs++; $display("FAIL b2b_count got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++; if (got[i] !== want[i]) begin errs++; $display("FAIL b2b_value %0d got %h want %h", i, got[i], want[i]); end
         if (i > 0) begin
            checks++; if (at[i] - at[i-1] != SETTLE + 2) begin errs++; $display("FAIL b2b_spacing %0d got %0d want %0d", i, at[i] - at[i-1], SETTLE + 2); end
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [2:0] c;
      logic [W-1:0] a, b, r;
      logic [W+1:0] e;
      logic ar;
      for (int k = 0; k < 30; k++) begin
         c = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
         e = alu_ref(c, a, b); ar = c == ADD_ || c == SUB_; r = e[W-1:0];
         send(c, a, b, lat);
         checks++; if (lat != SETTLE) begin errs++; $display("FAIL rnd_latency %0d got %0d want %0d", k, lat, SETTLE); end
         checks++; if (rsp_R !== r) begin errs++; $display("FAIL rnd_R %0d op=%0d got %h want %h", k, c, rsp_R, r); end
         checks++; if ({rsp_overflow, rsp_cout} !== (ar ? e[W+1:W] : 2'b00)) begin errs++; $display("FAIL rnd_flags %0d op=%0d got %b want %b", k, c, {rsp_overflow, rsp_cout}, ar ? e[W+1:W] : 2'b00); end
         checks++; if (rsp_zero !== (r == 0)) begin errs++; $display("FAIL rnd_zero %0d got %b want %b", k, rsp_zero, r == 0); end
         checks++; if (rsp_Ctrl !== c) begin errs++; $display("FAIL rnd_Ctrl %0d got %0d want %0d", k, rsp_Ctrl, c); end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         release_rsp();
      end
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      cmd_valid = 1; cmd_Ctrl = ADD_; cmd_A = 4'h3; cmd_B = 4'h3;
      @(posedge clk); #1 cmd_valid = 0;
      checks++; if ({busy, alu_A} !== {1'b1, 4'h3}) begin errs++; $display("FAIL abort_accept got %h want 13", {busy, alu_A}); end
      #1 rst_n = 0;
      #1 checks++;
      if ({cmd_ready, busy, rsp_valid, alu_Ctrl, alu_A, alu_B, rsp_R, rsp_cout, rsp_overflow, rsp_zero, rsp_Ctrl} !== 24'h800000) begin
         errs++; $display("FAIL abort_outputs got %h want 800000", {cmd_ready, busy, rsp_valid, alu_Ctrl, alu_A, alu_B, rsp_R, rsp_cout, rsp_overflow, rsp_zero, rsp_Ctrl});
      end
      @(negedge clk) rst_n = 1;
      rsp_ready = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errs++; $display("FAIL abort_no_rsp cyc=%0d got %b want 01", i, {rsp_valid, cmd_ready}); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Clocked initiator that issues operations to the combinational ALU. Accepts one command per valid/ready handshake and drives Ctrl/A/B to the ALU. Holds the operands stable for SETTLE cycles to cover the ALU's gate delays, then samples R/cout/overflow. Returns a registered response over a second valid/ready handshake. Bridges the ALU into synchronous datapaths and benches.

Parameters:
W, 4, operand/result width; must match the attached ALU's W.
SETTLE, 2, clock cycles between driving operands and sampling results; legal range 1..15.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_Ctrl  input  3  opcode (`ADD_, `SUB_, `XOR_, `SLT_, `AND_, `NAND_, `NOR_, `OR_ from defines.v).
cmd_A  input  W  operand A.
cmd_B  input  W  operand B.
alu_Ctrl  output  3  registered opcode to the ALU.
alu_A  output  W  registered operand A to the ALU.
alu_B  output  W  registered operand B to the ALU.
alu_R  input  W  ALU result.
alu_cout  input  1  ALU carry out.
alu_overflow  input  1  ALU overflow.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_R  output  W  captured result.
rsp_cout  output  1  captured carry; meaningful for ADD/SUB only.
rsp_overflow  output  1  captured overflow; meaningful for ADD/SUB only.
rsp_zero  output  1  captured result equals zero.
rsp_Ctrl  output  3  echo of the opcode that produced this response.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; settle counter clears.
  - All outputs 0 except cmd_ready=1: alu_Ctrl/alu_A/alu_B=0, rsp_*=0, rsp_valid=0, busy=0.
- FSM with three states: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On a clk edge with cmd_valid=1, the command is accepted: alu_Ctrl/alu_A/alu_B load cmd_*, counter loads SETTLE-1, state goes to SETTLE.
  - With cmd_valid=0, state and outputs hold.
- SETTLE:
  - cmd_ready=0.
  - The counter decrements each edge.
  - On the edge where the counter is 0: rsp_R<=alu_R, rsp_zero<=(alu_R==0), rsp_Ctrl<=alu_Ctrl, rsp_valid<=1, state goes to RESP.
  - rsp_cout<=alu_cout and rsp_overflow<=alu_overflow only when alu_Ctrl is `ADD_ or `SUB_; otherwise both load 0. The ALU leaves these undriven for other opcodes.
- RESP:
  - cmd_ready=0; rsp_* held stable.
  - On an edge with rsp_ready=1: rsp_valid<=0, state goes to IDLE. rsp_R and the flags keep their last values.
- alu_Ctrl/alu_A/alu_B change only on command acceptance. They are held through SETTLE and RESP and after return to IDLE.
- Latency: accept edge N gives rsp_valid=1 after edge N+SETTLE.
- Minimum command period: SETTLE+2 cycles with rsp_ready tied high.
- cmd_* are don't-care while cmd_ready=0, and no command is accepted then. Commands cannot be lost because cmd_ready gates acceptance.
- The response handshake in RESP and command acceptance never occur on the same edge; cmd_ready is a pure function of state.
- Reset during SETTLE or RESP aborts the operation: the response is discarded and no rsp_valid pulse appears after rsp_rises.
- SLT: rsp_R carries whatever the ALU returns, with no post-processing. rsp_zero is computed on the captured W-bit value.
- Width rules: all operands and results are W bits with no extension or truncation. rsp_zero is the reduction NOR of the captured alu_R.

Test Plan:
- W=4, SETTLE=2, real ALU attached: `ADD_ A=4'h7 B=4'h2 -> rsp_valid rises exactly 2 edges after accept; rsp_R=4'h9, rsp_cout=0, rsp_zero=0, rsp_Ctrl=`ADD_.
- `ADD_ A=4'hF B=4'h1 -> rsp_R=4'h0, rsp_cout=1, rsp_zero=1.
- `SUB_ A=4'h5 B=4'h5 -> rsp_R=4'h0, rsp_zero=1. Then `XOR_ A=4'hA B=4'h5 with ALU cout still high -> rsp_R=4'hF, rsp_cout=0, rsp_overflow=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid, toggling cmd_valid and cmd_* -> cmd_ready=0, alu_* and rsp_* unchanged, busy=1. rsp_ready=1 -> rsp_valid falls next edge and cmd_ready=1.
- Back-to-back: cmd_valid and rsp_ready held high with 4 commands (`AND_, `OR_, `NAND_, `NOR_ on A=4'hC B=4'hA) -> responses 4'h8, 4'hE, 4'h7, 4'h1 in order, spaced 4 cycles apart.
- Assert rst_n=0 during SETTLE of `ADD_ 4'h3+4'h3 -> all outputs immediately 0 (cmd_ready=1). After release, no rsp_valid until a new command is accepted.
